// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-priority search, registered one-hot grant and ID,
// tenure held until done, request withdrawal or the hold limit.
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           none_on
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic           release_c;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] search_ptr;
  logic [IDW:0]   cand;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic [N-1:0]   win_onehot;

  assign next_ptr   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
  // On release the search already uses the rotated pointer, so the old owner ranks last.
  assign search_ptr = (state_q == GRANT) ? next_ptr : ptr_q;
  assign release_c  = done || !req[id_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));
  assign win_onehot = N'(1) << win_idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = N; off > 0; off--) begin
      cand = {1'b0, search_ptr} + (IDW + 1)'(off - 1);
      if (cand >= (IDW + 1)'(N)) cand = cand - (IDW + 1)'(N);
      if (req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = grant_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          id_d    = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (win_found) begin
            grant_d = win_onehot;
            id_d    = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = valid_q;
  assign none_on     = ~|req;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an owner/pointer model.
module tb_rr_grant_arbiter;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           done = 1'b0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           none_on;

  int n_pass  = 0;
  int n_total = 0;

  rr_grant_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .none_on(none_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: owner index (-1 = idle), priority pointer, cycles shown in the current tenure.
  int m_owner, m_ptr, m_cycles, m_id;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cycles = 0; m_id = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_id = w; m_cycles = 1; end
    end else if (done || !req[m_owner] || (MAX_HOLD != 0 && m_cycles == MAX_HOLD)) begin
      m_ptr = (m_owner + 1) % N;
      w = pick(req, m_ptr);
      m_owner = w;
      m_cycles = 1;
      if (w >= 0) m_id = w;
    end else begin
      m_cycles++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_grant", int'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model_id", int'(grant_id), m_id);
      chk("model_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
      chk("model_none_on", int'(none_on), (req == '0) ? 1 : 0);
    end
  end

  // Inputs change at posedge+2; directed checks sample at posedge+3.
  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic next_cyc();
    @(posedge clk); #3;
  endtask

  initial begin
    int exp_id;
    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      chk("t1_grant", int'(grant), 0);
      chk("t1_valid", int'(grant_valid), 0);
      chk("t1_none_on", int'(none_on), 1);
    end

    // 2: two requesters, one-cycle tenures alternate
    do_reset();
    req = 8'h81; done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      chk("t2_id", int'(grant_id), (i % 2 == 0) ? 0 : 7);
      chk("t2_grant", int'(grant), (i % 2 == 0) ? 8'h01 : 8'h80);
      chk("t2_valid", int'(grant_valid), 1);
    end

    // 3: all requesting, strict rotation
    do_reset();
    req = 8'hFF; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      chk("t3_id", int'(grant_id), i % 8);
    end

    // 4: hold limit hands the grant over every MAX_HOLD cycles
    do_reset();
    req = 8'h06; done = 1'b0;
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      next_cyc();
      exp_id = ((i / MAX_HOLD) % 2 == 0) ? 1 : 2;
      chk("t4_id", int'(grant_id), exp_id);
      chk("t4_valid", int'(grant_valid), 1);
    end

    // 5: withdrawal goes idle and advances the pointer
    do_reset();
    req = 8'h08;
    next_cyc();
    chk("t5_id3", int'(grant_id), 3);
    req = 8'h00;
    next_cyc();
    chk("t5_grant0", int'(grant), 0);
    chk("t5_valid0", int'(grant_valid), 0);
    req = 8'h11;
    next_cyc();
    chk("t5_id4", int'(grant_id), 4);

    // 6: asynchronous reset mid-tenure
    do_reset();
    req = 8'h20;
    next_cyc();
    chk("t6_id5", int'(grant_id), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", int'(grant), 0);
    chk("t6_async_valid", int'(grant_valid), 0);
    @(posedge clk); #2;
    rst_n = 1'b1; req = 8'h21;
    next_cyc();
    chk("t6_id0", int'(grant_id), 0);

    // Random traffic, requests held for stretches so hold limits also fire
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = '0;
          1:       req = N'(1) << $urandom_range(0, N - 1);
          default: req = N'($urandom);
        endcase
      end
      done = ($urandom_range(0, 9) == 0);
    end

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
